// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key-flag bit positions and state types for the PS/2 key decoder.
// Build option: PS2_PARITY_CHECK_EN (used by ps2_frame_rx) turns on odd-parity enforcement.
package ps2_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam int KEY_ENTER = 0;
  localparam int KEY_Z     = 1;
  localparam int KEY_X     = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;
  localparam int NUM_KEYS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rxState_t;

  typedef enum logic [1:0] {
    BASE,
    EXT,
    BRK,
    EXTBRK
  } decState_t;

  // Numpad 6B/74 share codes with the arrows but lack the E0 prefix, so they fall through unmapped.
  function automatic logic [NUM_KEYS-1:0] keyMask(input logic extended, input logic [7:0] code);
    keyMask = '0;
    if (extended) begin
      case (code)
        SC_LEFT:  keyMask[KEY_LEFT]  = 1'b1;
        SC_RIGHT: keyMask[KEY_RIGHT] = 1'b1;
        SC_ENTER: keyMask[KEY_ENTER] = 1'b1;
        default:  keyMask = '0;
      endcase
    end else begin
      case (code)
        SC_ENTER: keyMask[KEY_ENTER] = 1'b1;
        SC_Z:     keyMask[KEY_Z]     = 1'b1;
        SC_X:     keyMask[KEY_X]     = 1'b1;
        default:  keyMask = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect, 11-bit framing and timeout.
// Build option: PS2_PARITY_CHECK_EN makes a failed odd-parity check reject the byte with an error pulse.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   clkHist;
  logic                   clkIn;
  logic                   dataIn;
  logic                   fallEdge;

  rxState_t      state, stateNext;
  logic [2:0]    bitCount, bitCountNext;
  logic [7:0]    shiftReg, shiftNext;
  logic [CW-1:0] idleCount, idleNext;
  logic          validNext;
  logic          errorNext;
  logic          parityAccept;

`ifdef PS2_PARITY_CHECK_EN
  logic parityOk, parityOkNext;
  assign parityAccept = parityOk;
`else
  assign parityAccept = 1'b1;
`endif

  assign clkIn    = clkSync[SYNC_STAGES-1];
  assign dataIn   = dataSync[SYNC_STAGES-1];
  assign fallEdge = clkHist & ~clkIn;

  // Framing decisions happen only on a detected PS/2 falling edge; otherwise the watchdog runs.
  always_comb begin
    stateNext    = state;
    bitCountNext = bitCount;
    shiftNext    = shiftReg;
    validNext    = 1'b0;
    errorNext    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parityOkNext = parityOk;
`endif
    if (fallEdge || state == IDLE) begin
      idleNext = '0;
    end else begin
      idleNext = idleCount + 1'b1;
    end

    if (fallEdge) begin
      unique case (state)
        IDLE: begin
          if (!dataIn) begin
            stateNext    = DATA;
            bitCountNext = '0;
          end else begin
            errorNext = 1'b1;
          end
        end
        DATA: begin
          shiftNext    = {dataIn, shiftReg[7:1]};
          bitCountNext = bitCount + 3'd1;
          if (bitCount == 3'd7) begin
            stateNext = PARITY;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parityOkNext = ^{shiftReg, dataIn};
`endif
          stateNext = STOP;
        end
        STOP: begin
          stateNext = IDLE;
          if (dataIn && parityAccept) begin
            validNext = 1'b1;
          end else begin
            errorNext = 1'b1;
          end
        end
      endcase
    end else if (state != IDLE && idleCount == TIMEOUT_LAST) begin
      stateNext = IDLE;
      errorNext = 1'b1;
    end
  end

  // Pins idle high, so the synchronizers reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      clkSync   <= '1;
      dataSync  <= '1;
      clkHist   <= 1'b1;
      state     <= IDLE;
      bitCount  <= '0;
      shiftReg  <= '0;
      idleCount <= '0;
      rxByte    <= '0;
      rxValid   <= 1'b0;
      rxError   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parityOk  <= 1'b0;
`endif
    end else begin
      clkSync   <= {clkSync[SYNC_STAGES-2:0], ps2Clk};
      dataSync  <= {dataSync[SYNC_STAGES-2:0], ps2Data};
      clkHist   <= clkIn;
      state     <= stateNext;
      bitCount  <= bitCountNext;
      shiftReg  <= shiftNext;
      idleCount <= idleNext;
      rxValid   <= validNext;
      rxError   <= errorNext;
      if (validNext) begin
        rxByte <= shiftReg;
      end
`ifdef PS2_PARITY_CHECK_EN
      parityOk  <= parityOkNext;
`endif
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: frames bytes via ps2_frame_rx and tracks held state of five game keys.
// Build option: PS2_PARITY_CHECK_EN (passed through to ps2_frame_rx) enables parity rejection.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] ScanCode,
  output logic       ScanValid,
  output logic       FrameError,
  output logic       isEnter,
  output logic       isZ,
  output logic       isX,
  output logic       isLeft,
  output logic       isRight
);

  decState_t             decState, decNext;
  logic [NUM_KEYS-1:0]   keyFlags, flagsNext;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) uFrameRx (
    .clk    (Clock),
    .resetN (Reset),
    .ps2Clk (PS2Clk),
    .ps2Data(PS2Data),
    .rxByte (ScanCode),
    .rxValid(ScanValid),
    .rxError(FrameError)
  );

  // Prefix tracking: E0 marks extended, F0 marks release; anything else completes the sequence.
  always_comb begin
    decNext   = decState;
    flagsNext = keyFlags;
    if (FrameError) begin
      decNext = BASE;
    end else if (ScanValid) begin
      unique case (decState)
        BASE, EXT: begin
          if (ScanCode == SC_EXT) begin
            decNext = EXT;
          end else if (ScanCode == SC_BREAK) begin
            decNext = (decState == EXT) ? EXTBRK : BRK;
          end else begin
            flagsNext = keyFlags | keyMask(decState == EXT, ScanCode);
            decNext   = BASE;
          end
        end
        BRK, EXTBRK: begin
          flagsNext = keyFlags & ~keyMask(decState == EXTBRK, ScanCode);
          decNext   = BASE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      decState <= BASE;
      keyFlags <= '0;
    end else begin
      decState <= decNext;
      keyFlags <= flagsNext;
    end
  end

  assign isEnter = keyFlags[KEY_ENTER];
  assign isZ     = keyFlags[KEY_Z];
  assign isX     = keyFlags[KEY_X];
  assign isLeft  = keyFlags[KEY_LEFT];
  assign isRight = keyFlags[KEY_RIGHT];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus random frames against a queue-based model.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 200;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] ScanCode;
  logic       ScanValid, FrameError;
  logic       isEnter, isZ, isX, isLeft, isRight;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         isErr;
    logic [7:0] code;
  } event_t;

  event_t     expQ[$];
  event_t     monE;
  bit         modelExt = 1'b0;
  bit         modelBrk = 1'b0;
  bit [4:0]   modelFlags = '0;
  int         keyMap[bit [8:0]];
  logic [7:0] pool[7] = '{8'hE0, 8'hF0, 8'h5A, 8'h1A, 8'h22, 8'h6B, 8'h74};

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .Clock     (clk),
    .Reset     (resetN),
    .PS2Clk    (ps2Clk),
    .PS2Data   (ps2Data),
    .ScanCode  (ScanCode),
    .ScanValid (ScanValid),
    .FrameError(FrameError),
    .isEnter   (isEnter),
    .isZ       (isZ),
    .isX       (isX),
    .isLeft    (isLeft),
    .isRight   (isRight)
  );

  always #5 clk = ~clk;

  // Reference model: a held-key set driven by prefix flags and a lookup table of mapped codes.
  function automatic void modelByte(input logic [7:0] code);
    if (!modelBrk && code == 8'hE0) begin
      modelExt = 1'b1;
    end else if (!modelBrk && code == 8'hF0) begin
      modelBrk = 1'b1;
    end else begin
      if (keyMap.exists({modelExt, code})) modelFlags[keyMap[{modelExt, code}]] = !modelBrk;
      modelExt = 1'b0;
      modelBrk = 1'b0;
    end
  endfunction

  function automatic void modelErr();
    modelExt = 1'b0;
    modelBrk = 1'b0;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic psBit(input logic b);
    ps2Data = b;
    waitCycles(2);
    ps2Clk = 1'b0;
    waitCycles(4);
    ps2Clk = 1'b1;
    waitCycles(2);
  endtask

  task automatic checkOutput(input string name);
    @(negedge clk);
    total++;
    if ({isRight, isLeft, isX, isZ, isEnter} !== modelFlags) begin
      bad++;
      $display("[TB] FAIL %s flags got=%b exp=%b", name,
               {isRight, isLeft, isX, isZ, isEnter}, modelFlags);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit flipParity, input bit badStop);
    logic   par;
    event_t e;
    par = ~^code;
    if (flipParity) par = ~par;
    e.code = code;
    e.isErr = badStop || (flipParity && PARITY_EN);
    expQ.push_back(e);
    if (e.isErr) modelErr();
    else modelByte(code);
    psBit(1'b0);
    for (int i = 0; i < 8; i++) psBit(code[i]);
    psBit(par);
    psBit(!badStop);
    waitCycles(4);
  endtask

  // Monitor: every valid or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetN && (ScanValid || FrameError)) begin
      total++;
      if (ScanValid && FrameError) begin
        bad++;
        $display("[TB] FAIL pulse_overlap valid=%b error=%b exp=exclusive", ScanValid, FrameError);
      end else if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse valid=%b error=%b code=%h exp=none",
                 ScanValid, FrameError, ScanCode);
      end else begin
        monE = expQ.pop_front();
        if (monE.isErr != FrameError || (!monE.isErr && ScanCode !== monE.code)) begin
          bad++;
          $display("[TB] FAIL scoreboard got err=%b code=%h exp err=%b code=%h",
                   FrameError, ScanCode, monE.isErr, monE.code);
        end
      end
    end
  end

  initial begin
    logic [7:0] code;
    event_t     e;
    keyMap[{1'b0, 8'h5A}] = 0;
    keyMap[{1'b0, 8'h1A}] = 1;
    keyMap[{1'b0, 8'h22}] = 2;
    keyMap[{1'b1, 8'h6B}] = 3;
    keyMap[{1'b1, 8'h74}] = 4;
    keyMap[{1'b1, 8'h5A}] = 0;

    waitCycles(5);
    @(negedge clk);
    total++;
    if ({ScanCode, ScanValid, FrameError} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=000", {ScanCode, ScanValid, FrameError});
    end
    checkOutput("reset_flags");
    resetN = 1'b1;
    waitCycles(5);

    applyStimulus(8'h1A, 0, 0);  checkOutput("make_z");
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h1A, 0, 0);  checkOutput("break_z");
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h6B, 0, 0);  checkOutput("make_left");
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'h74, 0, 0);  checkOutput("make_right");
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h6B, 0, 0);  checkOutput("break_left");
    applyStimulus(8'h22, 1, 0);  checkOutput("bad_parity_x");
    applyStimulus(8'h1A, 0, 1);  checkOutput("bad_stop_z");

    e.isErr = 1'b1;
    e.code  = 8'h00;
    expQ.push_back(e);
    modelErr();
    psBit(1'b0);
    for (int i = 0; i < 4; i++) psBit(1'b1);
    waitCycles(TIMEOUT + 20);
    checkOutput("timeout");
    applyStimulus(8'h5A, 0, 0);  checkOutput("enter_after_timeout");

    applyStimulus(8'h6B, 0, 0);  checkOutput("numpad_ignored");
    for (int i = 0; i < 3; i++) applyStimulus(8'h5A, 0, 0);
    checkOutput("typematic_enter");
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h5A, 0, 0);  checkOutput("break_enter");

    applyStimulus(8'h1A, 0, 0);  checkOutput("z_before_reset");
    psBit(1'b0);
    psBit(1'b1);
    psBit(1'b0);
    psBit(1'b1);
    @(posedge clk);
    #1 resetN = 1'b0;
    @(posedge clk);
    #1 resetN = 1'b1;
    modelFlags = '0;
    modelErr();
    waitCycles(3);
    checkOutput("mid_frame_reset");
    @(negedge clk);
    total++;
    if (ScanCode !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_scancode got=%h exp=00", ScanCode);
    end
    waitCycles(TIMEOUT + 20);
    applyStimulus(8'h22, 0, 0);  checkOutput("frame_after_reset");

    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = $urandom_range(0, 8);
      code = (sel < 7) ? pool[sel] : 8'($urandom_range(0, 255));
      applyStimulus(code, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      checkOutput("random_flags");
    end

    waitCycles(20);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_pulses got=%0d pending exp=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the PS/2 keyboard serial stream, frames 11-bit device-to-host packets, and decodes set-2 make/break scan codes into level flags for the five game keys (Enter, Z, X, Left, Right). It sits between the board's PS/2 pins and the game loop, which consumes `isEnter`/`isZ`/`isX`/`isLeft`/`isRight` as "key currently held" levels.

## Interface
- `TIMEOUT_CYCLES`, 10000 — Clock cycles without a PS/2 falling edge before a partial frame is abandoned.
- `SYNC_STAGES`, 2 — synchronizer depth for `PS2Clk`/`PS2Data`; minimum 2.
- `Clock` in 1 — system clock; single clock domain.
- `Reset` in 1 — synchronous, active-low reset.
- `PS2Clk` in 1 — raw PS/2 clock from pin, asynchronous.
- `PS2Data` in 1 — raw PS/2 data from pin, asynchronous.
- `ScanCode` out 8 — last correctly framed byte.
- `ScanValid` out 1 — one-cycle pulse; `ScanCode` is new this cycle.
- `FrameError` out 1 — one-cycle pulse on a bad start/stop bit, parity failure, or timeout.
- `isEnter`, `isZ`, `isX`, `isLeft`, `isRight` out 1 each — held-key levels.

## Operation
- Both pins pass through `SYNC_STAGES` flops, then one extra history flop on clock; a falling edge is sync-out 0 with history 1.
- Frame receiver states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge, sample data; 0 goes to DATA with bit count 0; 1 pulses `FrameError` and stays in IDLE.
  - DATA: shift LSB-first on each edge; after the 8th bit go to PARITY.
  - PARITY: sample on edge and check odd parity over data plus parity bit; go to STOP.
  - STOP: sample on edge. With stop bit 1 and parity good, pulse `ScanValid`; otherwise pulse `FrameError`. Return to IDLE either way.
- Timeout: the idle counter resets on every edge. Reaching `TIMEOUT_CYCLES` while not in IDLE forces IDLE and pulses `FrameError`. Partial bytes are discarded.
- Scan-code FSM states: BASE, EXT (saw E0), BRK (saw F0), EXTBRK (saw E0 F0). It consumes only valid bytes.
  - In BASE or EXT: E0 goes to EXT; F0 from BASE goes to BRK; F0 from EXT goes to EXTBRK.
  - Any other byte is a make code. It sets the mapped flag and returns to BASE.
  - In BRK or EXTBRK: the byte is a break code. It clears the mapped flag and returns to BASE.
- Key map:
  - Non-extended: 5A→isEnter, 1A→isZ, 22→isX.
  - Extended: 6B→isLeft, 74→isRight.
  - Non-extended 6B/74 are numpad keys and are ignored. Extended 5A is keypad Enter and maps to isEnter.
  - Unmapped codes change no flag but still complete the prefix sequence.
- Typematic repeat (repeated make codes) keeps the flag at 1; it is idempotent.
- A `FrameError` resets the scan-code FSM to BASE. Key flags hold their values.
- Left and Right may both be 1; no arbitration here.

## Timing
- Reset: all outputs 0, `ScanCode`=00, both FSMs in IDLE/BASE, counters 0. Reset mid-frame discards the frame with no `FrameError` pulse.
- Let N be the cycle the stop-bit edge is detected. `ScanValid` and `ScanCode` are valid at N+1, and key flags update at N+2.
- The pin-to-edge-detect latency is `SYNC_STAGES`+1 cycles.
- `ScanValid` and `FrameError` are never asserted in the same cycle.
- There is no handshake. The consumer must sample `ScanValid` pulses every cycle.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity failure rejects the byte and pulses `FrameError`.
- Not defined: the parity bit is sampled and ignored, and only start/stop/timeout errors pulse `FrameError`.

## Structure
- Shared package `ps2_pkg`: scan-code constants (`SC_ENTER`=5A, `SC_Z`=1A, `SC_X`=22, `SC_LEFT`=6B, `SC_RIGHT`=74, `SC_EXT`=E0, `SC_BREAK`=F0) and the receiver and decoder state enums.
- Sub-module `ps2_frame_rx`: synchronizer, edge detect, framing, parity, and timeout. It outputs byte, valid, and error. The top level holds the scan-code FSM and key flags.

## Test plan
- Frame 1A (start 0, data LSB-first, parity 0, stop 1) → `ScanValid`, `ScanCode`=1A, `isZ`=1; then F0,1A → `isZ`=0.
- E0,6B → `isLeft`=1, `isRight`=0; then E0,74 → both 1; then E0,F0,6B → `isLeft`=0, `isRight`=1.
- Byte 22 with parity bit flipped, macro defined → `FrameError` pulse, no `ScanValid`, `isX` stays 0. Same frame without macro → `isX`=1.
- Clock out 5 bits, then idle `TIMEOUT_CYCLES` → `FrameError` pulse. A following clean 5A → `isEnter`=1.
- Send 6B non-extended → no flag changes. Send 5A,5A,5A (repeat) → `isEnter` stays 1; then F0,5A → 0.
- Assert `Reset` low for one cycle mid-frame with `isZ`=1 → all flags 0, no `FrameError`. The next full frame decodes correctly.
